shift_register: RTL and testbench

SHIFT_REGISTER -- requirements
Module: shift_register

---
 rtl/shift_register_pkg.sv | 18 +
 rtl/shift_register_scan_mux_dff.sv | 39 +++
 rtl/shift_register.sv | 86 ++++++++
 tb/tb_shift_register.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/shift_register_pkg.sv
// -----------------------------------------------------------------------------
// shift_register_pkg
//   Shared constants and types for the scan-capable shift register.
//   - DEFAULT_WIDTH        : default number of register stages
//   - DEFAULT_RESET_VALUE  : default reset load value (sliced to WIDTH bits)
//   - mode_e               : decoding of scan_en (normal vs scan source)
// -----------------------------------------------------------------------------
package shift_register_pkg;

    localparam int          DEFAULT_WIDTH       = 4;
    localparam logic [63:0] DEFAULT_RESET_VALUE = 64'd0;

    typedef enum logic {
        MODE_NORMAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

endpackage : shift_register_pkg

// File: rtl/shift_register_scan_mux_dff.sv
// -----------------------------------------------------------------------------
// scan_mux_dff
//   One mux-D flip-flop: loads si in scan mode, d in normal mode, and rst_val
//   on a synchronous active-high reset.
//   Ports:
//     clk     in  clock, rising edge
//     rst     in  synchronous active-high reset
//     rst_val in  value loaded on reset
//     se      in  scan enable (1 = take si, 0 = take d)
//     si      in  scan data
//     d       in  functional data
//     q       out registered output
// -----------------------------------------------------------------------------
module scan_mux_dff
    import shift_register_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic se,
    input  logic si,
    input  logic d,
    output logic q
);

    // NOTE: reset is tested inside the clocked block and kept out of the
    // sensitivity list, which makes it synchronous; state uses <= so every
    // stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= rst_val;
        end else if (mode_e'(se) == MODE_SCAN) begin
            q <= si;
        end else begin
            q <= d;
        end
    end

endmodule : scan_mux_dff

// File: rtl/shift_register.sv
// -----------------------------------------------------------------------------
// shift_register
//   WIDTH-stage left-shifting register built from mux-D scan flops. Each
//   non-reset rising edge shifts q left by one; q[0] takes scan_in when
//   scan_en=1, otherwise d. The old MSB is dropped (no wrap-around).
//   Parameters:
//     WIDTH        number of stages (2..64)
//     RESET_VALUE  value loaded into q on reset
//   Ports:
//     clk      in  clock, rising edge
//     rst      in  synchronous active-high reset (overrides all other inputs)
//     scan_en  in  1 = scan mode (serial source scan_in), 0 = normal (d)
//     scan_in  in  serial scan data
//     d        in  serial functional data
//     q        out register contents, straight from the flops
//     scan_out out copy of q[WIDTH-1]
//     parity   out (only with SHIFT_REGISTER_PARITY_EN) registered ^q
//   Configuration macro: SHIFT_REGISTER_PARITY_EN adds the parity output.
// -----------------------------------------------------------------------------
module shift_register
    import shift_register_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = DEFAULT_RESET_VALUE[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scan_en,
    input  logic             scan_in,
    input  logic             d,
    output logic [WIDTH-1:0] q,
    output logic             scan_out
`ifdef SHIFT_REGISTER_PARITY_EN
    ,
    output logic             parity
`endif
);

    // Stage 0 selects between the two serial inputs; every later stage feeds
    // the same neighbour bit to both mux legs so scan_en cannot disturb data
    // already inside the chain.
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            scan_mux_dff u_dff (
                .clk     (clk),
                .rst     (rst),
                .rst_val (RESET_VALUE[i]),
                .se      (scan_en),
                .si      (scan_in),
                .d       (d),
                .q       (q[i])
            );
        end else begin : g_tail
            scan_mux_dff u_dff (
                .clk     (clk),
                .rst     (rst),
                .rst_val (RESET_VALUE[i]),
                .se      (scan_en),
                .si      (q[i-1]),
                .d       (q[i-1]),
                .q       (q[i])
            );
        end
    end

    assign scan_out = q[WIDTH-1];

`ifdef SHIFT_REGISTER_PARITY_EN
    // Parity is computed from the value q is about to take, so the registered
    // bit matches ^q in the same cycle rather than lagging by one edge.
    logic [WIDTH-1:0] q_next;

    always_comb begin
        q_next = {q[WIDTH-2:0], (mode_e'(scan_en) == MODE_SCAN) ? scan_in : d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity <= ^RESET_VALUE;
        end else begin
            parity <= ^q_next;
        end
    end
`endif

endmodule : shift_register

// File: tb/tb_shift_register.sv
// -----------------------------------------------------------------------------
// tb_shift_register
//   Self-checking bench for shift_register. Two instances run in lock-step on
//   the same inputs: the default 4-bit / zero-reset build and an 8-bit build
//   with a non-zero reset value. A behavioural model treats each register as
//   an integer: reset loads the reset value, otherwise value = (value*2 +
//   serial_bit) mod 2^WIDTH. Directed steps follow the documented scenarios,
//   then randomized stimulus runs against the model.
//   Honours SHIFT_REGISTER_PARITY_EN (parity compared against ^model).
// -----------------------------------------------------------------------------
module tb_shift_register;

    localparam int         W_A  = 4;
    localparam logic [3:0] RV_A = 4'b0000;
    localparam int         W_B  = 8;
    localparam logic [7:0] RV_B = 8'hA5;

    logic           clk;
    logic           rst;
    logic           scan_en;
    logic           scan_in;
    logic           d;
    logic [W_A-1:0] q_a;
    logic           so_a;
    logic [W_B-1:0] q_b;
    logic           so_b;
`ifdef SHIFT_REGISTER_PARITY_EN
    logic           par_a;
    logic           par_b;
`endif

    int          checks;
    int          errors;
    logic [63:0] model_a;
    logic [63:0] model_b;

    shift_register dut_a (
        .clk      (clk),
        .rst      (rst),
        .scan_en  (scan_en),
        .scan_in  (scan_in),
        .d        (d),
        .q        (q_a),
        .scan_out (so_a)
`ifdef SHIFT_REGISTER_PARITY_EN
        ,
        .parity   (par_a)
`endif
    );

    shift_register #(
        .WIDTH       (W_B),
        .RESET_VALUE (RV_B)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .scan_en  (scan_en),
        .scan_in  (scan_in),
        .d        (d),
        .q        (q_b),
        .scan_out (so_b)
`ifdef SHIFT_REGISTER_PARITY_EN
        ,
        .parity   (par_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Integer view of a shift register: reset value, or doubled plus new bit,
    // truncated to the register width.
    function automatic logic [63:0] next_value(input logic [63:0] cur, input int width,
                                               input logic [63:0] rv, input logic r,
                                               input logic serial);
        logic [63:0] modulus_mask;
        modulus_mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        if (r) return rv;
        return ((cur * 2) + {63'd0, serial}) & modulus_mask;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, "_qa"},  {60'd0, q_a}, model_a);
        check({tag, "_soa"}, {63'd0, so_a}, {63'd0, model_a[W_A-1]});
        check({tag, "_qb"},  {56'd0, q_b}, model_b);
        check({tag, "_sob"}, {63'd0, so_b}, {63'd0, model_b[W_B-1]});
`ifdef SHIFT_REGISTER_PARITY_EN
        check({tag, "_pa"},  {63'd0, par_a}, {63'd0, ^model_a});
        check({tag, "_pb"},  {63'd0, par_b}, {63'd0, ^model_b});
`endif
    endtask

    // Apply one set of inputs across a rising edge, advance the model and
    // compare 1 time unit after the edge.
    task automatic tick(input logic r, input logic se, input logic si, input logic dd,
                        input string tag);
        logic serial;
        rst     = r;
        scan_en = se;
        scan_in = si;
        d       = dd;
        serial  = se ? si : dd;
        model_a = next_value(model_a, W_A, {60'd0, RV_A}, r, serial);
        model_b = next_value(model_b, W_B, {56'd0, RV_B}, r, serial);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        model_a = '0;
        model_b = '0;
        rst     = 1'b0;
        scan_en = 1'b0;
        scan_in = 1'b0;
        d       = 1'b0;

        // Reset with all serial inputs low.
        tick(1'b1, 1'b0, 1'b0, 1'b0, "reset");
        check("reset_q",  {60'd0, q_a}, 64'h0);
        check("reset_so", {63'd0, so_a}, 64'h0);
        check("reset_qb", {56'd0, q_b}, 64'hA5);

        // Normal shift: d = 1,0,1.
        tick(1'b0, 1'b0, 1'b0, 1'b1, "norm1");
        check("norm1_q", {60'd0, q_a}, 64'h1);
        tick(1'b0, 1'b0, 1'b1, 1'b0, "norm2");
        check("norm2_q", {60'd0, q_a}, 64'h2);
        tick(1'b0, 1'b0, 1'b0, 1'b1, "norm3");
        check("norm3_q", {60'd0, q_a}, 64'h5);

        // Scan shift: scan_in = 1,0,1 with d driven opposite.
        tick(1'b0, 1'b1, 1'b1, 1'b0, "scan1");
        check("scan1_q",  {60'd0, q_a}, 64'hB);
        check("scan1_so", {63'd0, so_a}, 64'h1);
        tick(1'b0, 1'b1, 1'b0, 1'b1, "scan2");
        check("scan2_q",  {60'd0, q_a}, 64'h6);
        check("scan2_so", {63'd0, so_a}, 64'h0);
        tick(1'b0, 1'b1, 1'b1, 1'b0, "scan3");
        check("scan3_q",  {60'd0, q_a}, 64'hD);
        check("scan3_so", {63'd0, so_a}, 64'h1);

        // Reset pulsed between edges must not change anything.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("midpulse_qa", {60'd0, q_a}, 64'hD);
        compare_all("midpulse");

        // Reset at an edge wins over scan_en / scan_in.
        tick(1'b1, 1'b1, 1'b1, 1'b1, "rstprio");
        check("rstprio_q", {60'd0, q_a}, 64'h0);

        // Mode isolation: scan mode ignores d.
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, "fill1");
        check("fill1_q", {60'd0, q_a}, 64'hF);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 1'b1, "iso_scan");
        check("iso_scan_q", {60'd0, q_a}, 64'h0);

        // Mode isolation: normal mode ignores scan_in.
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, "fill2");
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, "iso_norm");
        check("iso_norm_q", {60'd0, q_a}, 64'hF);

        // Randomized traffic, occasional reset.
        for (int i = 0; i < 200; i++) begin
            tick(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), 1'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_shift_register
